uart_rx: RTL and testbench

UART receiver for the CPU's serial port, on the consumer side of the `rx` line that the UART transmitter also carries.
- Synchronises the asynchronous `rx` pin and detects a start bit.
- Oversamples each bit 16x and takes a majority vote at mid-bit.
- Assembles 8N1 frames, LSB first, into a one-entry holding register.
- Presents each byte to the CPU-side bus interface over a valid/ready handshake.
- Reports framing and overrun errors as single-cycle pulses.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_tick_gen.sv | 46 ++++
 rtl/uart_rx.sv | 202 ++++++++++++++++++++
 tb/tb_uart_rx.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the 16x-oversampled 8N1 UART receiver.
// Also holds the baud divisor calculation so the transmitter can share it.
package uart_pkg;

   localparam int unsigned OVERSAMPLE = 16;
   localparam int unsigned DATA_BITS  = 8;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } rx_state_t;

   function automatic int unsigned calc_div(input int unsigned clk_freq,
                                            input int unsigned baud_rate);
      return clk_freq / (baud_rate * OVERSAMPLE);
   endfunction

   function automatic logic maj3(input logic [2:0] v);
      return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
   endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Free-running divide-by-DIV counter producing a one-clk oversample tick.
// 'clear' restarts the count so ticks can be phase-aligned to an event.
module uart_tick_gen #(
   parameter int unsigned DIV = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);

   localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);
   localparam logic [CW-1:0] ONE  = CW'(1);

   if (DIV < 2) begin : g_bad_div
      $error("uart_tick_gen: DIV must be at least 2");
   end

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // next count: restart on clear, wrap at DIV-1
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (cnt_q == LAST) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + ONE;
      end
   end

   // counter register
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises rx, oversamples 16x with a mid-bit 3-sample
// majority vote and hands bytes out through a one-entry valid/ready register.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ    = 50_000_000,
   parameter int unsigned BAUD_RATE   = 115_200,
   parameter int unsigned OVERSAMPLE  = 16,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data,
   output logic                 valid,
   input  logic                 ready,
   output logic                 frame_error,
   output logic                 overrun,
   output logic                 busy
);

   localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD_RATE);
   localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

   if (OVERSAMPLE != uart_pkg::OVERSAMPLE) begin : g_bad_os
      $error("uart_rx: OVERSAMPLE must be 16");
   end
   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("uart_rx: SYNC_STAGES must be at least 2");
   end
   if (DIV < 2) begin : g_bad_div
      $error("uart_rx: CLK_FREQ/(BAUD_RATE*16) must be at least 2");
   end

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q, prev_d;
   rx_state_t              state_q, state_d;
   logic [3:0]             smp_q, smp_d;
   logic [1:0]             vote_q, vote_d;
   logic [2:0]             idx_q, idx_d;
   logic [DATA_BITS-1:0]   shreg_q, shreg_d;
   logic [DATA_BITS-1:0]   data_q, data_d;
   logic                   valid_q, valid_d;
   logic                   ferr_q, ferr_d;
   logic                   ovr_q, ovr_d;
   logic                   busy_q, busy_d;

   logic rxs_s;
   logic start_s;
   logic tick_s;
   logic vote_tick_s;
   logic bound_tick_s;
   logic bit_s;

   assign rxs_s        = sync_q[SYNC_STAGES-1];
   assign start_s      = (state_q == IDLE) && prev_q && !rxs_s;
   assign vote_tick_s  = tick_s && (smp_q == 4'd9);
   assign bound_tick_s = tick_s && (smp_q == 4'd15);
   // samples 7 and 8 are held in vote_q; sample 9 joins directly from rxs
   assign bit_s        = maj3({vote_q, rxs_s});

   uart_tick_gen #(.DIV(DIV)) u_tick (
      .clk   (clk),
      .rst   (rst),
      .clear (start_s),
      .tick  (tick_s)
   );

   // synchroniser shift and edge-detect history
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], rx};
      prev_d = rxs_s;
   end

   // frame FSM, sample bookkeeping and output staging
   always_comb begin
      state_d = state_q;
      smp_d   = smp_q;
      vote_d  = vote_q;
      idx_d   = idx_q;
      shreg_d = shreg_q;
      data_d  = data_q;
      valid_d = valid_q && !ready;
      ferr_d  = 1'b0;
      ovr_d   = 1'b0;

      if ((state_q != IDLE) && tick_s) begin
         smp_d = smp_q + 4'd1;
         if (smp_q inside {[4'd7:4'd9]}) begin
            vote_d = {vote_q[0], rxs_s};
         end else begin
            vote_d = vote_q;
         end
      end else begin
         smp_d = smp_q;
      end

      case (state_q)
         IDLE: begin
            if (start_s) begin
               state_d = START;
               smp_d   = 4'd0;
               vote_d  = 2'b00;
               idx_d   = 3'd0;
            end else begin
               state_d = IDLE;
            end
         end
         START: begin
            if (vote_tick_s && bit_s) begin
               state_d = IDLE;
            end else if (bound_tick_s) begin
               state_d = DATA;
               idx_d   = 3'd0;
            end else begin
               state_d = START;
            end
         end
         DATA: begin
            if (vote_tick_s) begin
               shreg_d = {bit_s, shreg_q[DATA_BITS-1:1]};
            end else if (bound_tick_s) begin
               if (idx_q == LAST_IDX) begin
                  state_d = STOP;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end else begin
               state_d = DATA;
            end
         end
         STOP: begin
            // leaving at mid-stop lets a start edge half a bit later be caught
            if (vote_tick_s) begin
               if (!bit_s) begin
                  ferr_d  = 1'b1;
                  state_d = BREAK;
               end else if (!valid_q || ready) begin
                  data_d  = shreg_q;
                  valid_d = 1'b1;
                  state_d = IDLE;
               end else begin
                  ovr_d   = 1'b1;
                  state_d = IDLE;
               end
            end else begin
               state_d = STOP;
            end
         end
         BREAK: begin
            if (rxs_s) begin
               state_d = IDLE;
            end else begin
               state_d = BREAK;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   // all state and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q  <= '1;
         prev_q  <= 1'b1;
         state_q <= IDLE;
         smp_q   <= 4'd0;
         vote_q  <= 2'b00;
         idx_q   <= 3'd0;
         shreg_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         prev_q  <= prev_d;
         state_q <= state_d;
         smp_q   <= smp_d;
         vote_q  <= vote_d;
         idx_q   <= idx_d;
         shreg_q <= shreg_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
         ovr_q   <= ovr_d;
         busy_q  <= busy_d;
      end
   end

   assign data        = data_q;
   assign valid       = valid_q;
   assign frame_error = ferr_q;
   assign overrun     = ovr_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 160 clk per bit: expected bytes are queued as
// frames are sent and checked when the receiver hands them over.
module tb_uart_rx;

   localparam int BIT_CLK = 160;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx = 1'b1;
   logic       ready = 1'b1;
   logic [7:0] data;
   logic       valid;
   logic       frame_error;
   logic       overrun;
   logic       busy;

   int vectors = 0;
   int miscompares = 0;
   int acc_cnt = 0;
   int fe_cnt = 0;
   int ovr_cnt = 0;
   logic [7:0] exp_q[$];

   uart_rx #(
      .CLK_FREQ    (1_600_000),
      .BAUD_RATE   (10_000),
      .OVERSAMPLE  (16),
      .SYNC_STAGES (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .rx          (rx),
      .data        (data),
      .valid       (valid),
      .ready       (ready),
      .frame_error (frame_error),
      .overrun     (overrun),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // scoreboard side: every accepted byte must match the oldest queued one
   always @(negedge clk) begin
      if (!rst) begin
         if (frame_error) fe_cnt++;
         if (overrun) ovr_cnt++;
         if (valid && ready) begin
            acc_cnt++;
            check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("sb_data", 32'(data), 32'(exp_q.pop_front()));
         end
      end
   end

   task automatic drive_rx(input logic v, input int n);
      rx = v;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      drive_rx(1'b0, BIT_CLK);
      for (int i = 0; i < 8; i++) drive_rx(b[i], BIT_CLK);
      drive_rx(stop, BIT_CLK);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_data"}, 32'(data), 32'd0);
      check({tag, "_valid"}, 32'(valid), 32'd0);
      check({tag, "_ferr"}, 32'(frame_error), 32'd0);
      check({tag, "_ovr"}, 32'(overrun), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   int lat;
   logic [7:0] b77;

   initial begin
      // reset
      repeat (4) @(posedge clk);
      #1;
      check_outputs_zero("reset");
      rst = 1'b0;
      drive_rx(1'b1, 20);

      // clean byte with latency measurement
      exp_q.push_back(8'hA5);
      lat = 0;
      fork
         send_frame(8'hA5, 1'b1);
         begin
            while (!valid && lat < 2000) begin
               @(posedge clk);
               #1;
               lat++;
            end
         end
      join
      check("lat_min", 32'(lat >= 1523), 32'd1);
      check("lat_max", 32'(lat <= 1543), 32'd1);
      drive_rx(1'b1, 20);
      check("clean_acc", 32'(acc_cnt), 32'd1);
      check("clean_fe", 32'(fe_cnt), 32'd0);
      check("clean_ovr", 32'(ovr_cnt), 32'd0);

      // back-pressure and overrun
      ready = 1'b0;
      exp_q.push_back(8'h3C);
      send_frame(8'h3C, 1'b1);
      send_frame(8'hC3, 1'b1);
      drive_rx(1'b1, 20);
      check("bp_valid", 32'(valid), 32'd1);
      check("bp_data", 32'(data), 32'h3C);
      check("bp_ovr", 32'(ovr_cnt), 32'd1);
      check("bp_acc", 32'(acc_cnt), 32'd1);
      ready = 1'b1;
      drive_rx(1'b1, 3);
      check("bp_cleared", 32'(valid), 32'd0);
      check("bp_data_held", 32'(data), 32'h3C);
      check("bp_acc2", 32'(acc_cnt), 32'd2);

      // false start
      drive_rx(1'b0, 20);
      check("fs_busy", 32'(busy), 32'd1);
      drive_rx(1'b0, 20);
      drive_rx(1'b1, 300);
      check("fs_idle", 32'(busy), 32'd0);
      check("fs_valid", 32'(valid), 32'd0);
      check("fs_acc", 32'(acc_cnt), 32'd2);

      // 10-clk glitch on sample 8 of data bit 3 of 0xFF
      exp_q.push_back(8'hFF);
      drive_rx(1'b0, BIT_CLK);
      drive_rx(1'b1, 3 * BIT_CLK + 85);
      drive_rx(1'b0, 10);
      drive_rx(1'b1, 65 + 4 * BIT_CLK);
      drive_rx(1'b1, BIT_CLK + 20);
      check("glitch_acc", 32'(acc_cnt), 32'd3);
      check("glitch_data", 32'(data), 32'hFF);

      // framing error followed by a held-low break
      send_frame(8'h55, 1'b0);
      check("fe_pulse", 32'(fe_cnt), 32'd1);
      check("fe_busy", 32'(busy), 32'd1);
      drive_rx(1'b0, 3000 - BIT_CLK);
      check("brk_fe_once", 32'(fe_cnt), 32'd1);
      check("brk_busy", 32'(busy), 32'd1);
      check("brk_acc", 32'(acc_cnt), 32'd3);
      drive_rx(1'b1, 20);
      check("brk_idle", 32'(busy), 32'd0);
      exp_q.push_back(8'h12);
      send_frame(8'h12, 1'b1);
      drive_rx(1'b1, 20);
      check("after_brk_acc", 32'(acc_cnt), 32'd4);

      // back-to-back frames, no idle gap
      exp_q.push_back(8'h01);
      exp_q.push_back(8'h02);
      exp_q.push_back(8'h03);
      send_frame(8'h01, 1'b1);
      send_frame(8'h02, 1'b1);
      send_frame(8'h03, 1'b1);
      drive_rx(1'b1, 20);
      check("b2b_acc", 32'(acc_cnt), 32'd7);
      check("b2b_last", 32'(data), 32'h03);

      // reset during data bit 4 of 0x77; transmitter abandons the frame too
      b77 = 8'h77;
      drive_rx(1'b0, BIT_CLK);
      for (int i = 0; i < 4; i++) drive_rx(b77[i], BIT_CLK);
      drive_rx(b77[4], 80);
      check("pre_rst_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      drive_rx(1'b1, 1);
      rst = 1'b0;
      check_outputs_zero("midrst");
      drive_rx(1'b1, 2000);
      check("midrst_acc", 32'(acc_cnt), 32'd7);
      check("midrst_idle", 32'(busy), 32'd0);
      exp_q.push_back(8'h88);
      send_frame(8'h88, 1'b1);
      drive_rx(1'b1, 20);
      check("final_acc", 32'(acc_cnt), 32'd8);
      check("final_data", 32'(data), 32'h88);
      check("final_fe", 32'(fe_cnt), 32'd1);
      check("final_ovr", 32'(ovr_cnt), 32'd1);
      check("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
